ssd_scan_decoder: RTL and testbench

Receive-side counterpart of the seven-segment display controller. It samples a multiplexed 4-digit seven-segment bus (active-low anode enables plus active-low cathodes), waits for each digit's dwell to settle, and decodes the segment patterns back to hex nibbles. Once all four digits have been captured, it publishes a 16-bit value. The block is used for loopback self-test of the display path and for reading external scanned displays.

---
 rtl/ssd_pkg.sv | 30 +++
 rtl/ssd_seg_decode.sv | 35 +++
 rtl/ssd_scan_decoder.sv | 161 ++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment encodings and anode-enable constants used by both
// the scan controller and the scan decoder. Cathodes are active-low.
package ssd_pkg;

  // Bit order {g, f, e, d, c, b, a}; 'I' is not listed because it shares LedOne.
  typedef enum logic [6:0] {
    LedZero  = 7'b1000000,
    LedOne   = 7'b1111001,
    LedTwo   = 7'b0100100,
    LedThree = 7'b0110000,
    LedFour  = 7'b0011001,
    LedFive  = 7'b0010010,
    LedSix   = 7'b0000010,
    LedSeven = 7'b1111000,
    LedEight = 7'b0000000,
    LedNine  = 7'b0010000,
    LedA     = 7'b0001000,
    LedB     = 7'b0000011,
    LedC     = 7'b1000110,
    LedD     = 7'b0100001,
    LedE     = 7'b0000110,
    LedF     = 7'b0001110
  } led_chars_t;

  localparam logic [3:0] DigitEn0 = 4'b1110;
  localparam logic [3:0] DigitEn1 = 4'b1101;
  localparam logic [3:0] DigitEn2 = 4'b1011;
  localparam logic [3:0] DigitEn3 = 4'b0111;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment pattern to hex nibble lookup; unknown
// patterns return 0x0 with bad_o set.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] led_i,
  output logic [3:0] nibble_o,
  output logic       bad_o
);

  always_comb begin
    nibble_o = 4'h0;
    bad_o    = 1'b0;
    case (led_i)
      LedZero:  nibble_o = 4'h0;
      LedOne:   nibble_o = 4'h1;
      LedTwo:   nibble_o = 4'h2;
      LedThree: nibble_o = 4'h3;
      LedFour:  nibble_o = 4'h4;
      LedFive:  nibble_o = 4'h5;
      LedSix:   nibble_o = 4'h6;
      LedSeven: nibble_o = 4'h7;
      LedEight: nibble_o = 4'h8;
      LedNine:  nibble_o = 4'h9;
      LedA:     nibble_o = 4'hA;
      LedB:     nibble_o = 4'hB;
      LedC:     nibble_o = 4'hC;
      LedD:     nibble_o = 4'hD;
      LedE:     nibble_o = 4'hE;
      LedF:     nibble_o = 4'hF;
      default:  bad_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Samples a multiplexed 4-digit seven-segment bus, decodes each settled digit
// and publishes a 16-bit value once all four digits have been captured.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_digit_en,
  input  logic [6:0]  i_led,
  output logic [15:0] o_num_bcd,
  output logic [3:0]  o_bad,
  output logic        o_valid,
  output logic        o_stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SettleMax  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StCollect = 1'b1;

  logic [3:0]    en_meta_q, en_sync_q, en_prev_q;
  logic [6:0]    led_meta_q, led_sync_q, led_prev_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] idle_q, idle_d, idle_inc;
  logic          taken_q, taken_d;
  logic [0:0]    state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_bad_q, shadow_bad_d;
  logic [15:0]   num_q, num_d;
  logic [3:0]    bad_q, bad_d;
  logic          valid_d, stale_d;
  logic          legal, changed, sample, timeout;
  logic [3:0]    dig_oh;
  logic [3:0]    dec_nibble;
  logic          dec_bad;

  ssd_seg_decode u_seg_decode (
    .led_i    (led_sync_q),
    .nibble_o (dec_nibble),
    .bad_o    (dec_bad)
  );

  always_comb begin
    legal  = 1'b1;
    dig_oh = 4'b0000;
    unique case (en_sync_q)
      DigitEn0: dig_oh = 4'b0001;
      DigitEn1: dig_oh = 4'b0010;
      DigitEn2: dig_oh = 4'b0100;
      DigitEn3: dig_oh = 4'b1000;
      default:  legal  = 1'b0;
    endcase
  end

  assign changed = {en_sync_q, led_sync_q} != {en_prev_q, led_prev_q};

  // settle_d is the count of identical cycles preceding this one, so the
  // sample lands SETTLE_CYCLES-1 cycles after the synced value first appears.
  always_comb begin
    settle_d = settle_q;
    if (changed || !legal) begin
      settle_d = '0;
    end else if (settle_q != SettleMax) begin
      settle_d = settle_q + SW'(1);
    end
  end

  assign sample  = (settle_d == SettleMax) && !taken_q;
  assign taken_d = (changed || !legal) ? 1'b0 : (taken_q | sample);

  assign idle_inc = (idle_q == TimeoutVal) ? idle_q : idle_q + TW'(1);
  assign timeout  = (idle_q != TimeoutVal) && (idle_inc == TimeoutVal);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    shadow_bad_d = shadow_bad_q;
    idle_d       = idle_inc;
    num_d        = num_q;
    bad_d        = bad_q;
    valid_d      = 1'b0;
    stale_d      = o_stale;
    if (sample) begin
      idle_d  = '0;
      state_d = StCollect;
      for (int i = 0; i < 4; i++) begin
        if (dig_oh[i]) begin
          shadow_d[i*4 +: 4] = dec_nibble;
          shadow_bad_d[i]    = dec_bad;
          mask_d[i]          = 1'b1;
        end
      end
      if (mask_d == 4'hF) begin
        num_d   = shadow_d;
        bad_d   = shadow_bad_d;
        valid_d = 1'b1;
        stale_d = 1'b0;
        mask_d  = 4'h0;
        state_d = StIdle;
      end
    end else if (timeout) begin
      stale_d = 1'b1;
      if (state_q == StCollect) begin
        mask_d  = 4'h0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta_q    <= 4'hF;
      en_sync_q    <= 4'hF;
      en_prev_q    <= 4'hF;
      led_meta_q   <= 7'h7F;
      led_sync_q   <= 7'h7F;
      led_prev_q   <= 7'h7F;
      settle_q     <= '0;
      idle_q       <= '0;
      taken_q      <= 1'b0;
      state_q      <= StIdle;
      mask_q       <= 4'h0;
      shadow_q     <= 16'h0;
      shadow_bad_q <= 4'h0;
      num_q        <= 16'h0;
      bad_q        <= 4'h0;
      o_valid      <= 1'b0;
      o_stale      <= 1'b1;
    end else begin
      en_meta_q    <= i_digit_en;
      en_sync_q    <= en_meta_q;
      en_prev_q    <= en_sync_q;
      led_meta_q   <= i_led;
      led_sync_q   <= led_meta_q;
      led_prev_q   <= led_sync_q;
      settle_q     <= settle_d;
      idle_q       <= idle_d;
      taken_q      <= taken_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      shadow_bad_q <= shadow_bad_d;
      num_q        <= num_d;
      bad_q        <= bad_d;
      o_valid      <= valid_d;
      o_stale      <= stale_d;
    end
  end

  assign o_num_bcd = num_q;
  assign o_bad     = bad_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: frames, bad patterns, short dwells,
// illegal enables, timeout and mid-frame reset.
module tb_ssd_scan_decoder;

  localparam int unsigned Settle  = 1024;
  localparam int unsigned Timeout = 10000;
  localparam int Dwell = 1200;

  // Active-low {g,f,e,d,c,b,a} encodings for 0..F.
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  led = 7'h7F;
  logic [15:0] num_bcd;
  logic [3:0]  bad;
  logic        valid;
  logic        stale;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int valid_cnt = 0;
  int v0;

  ssd_scan_decoder #(
    .SETTLE_CYCLES  (Settle),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_digit_en (digit_en),
    .i_led      (led),
    .o_num_bcd  (num_bcd),
    .o_bad      (bad),
    .o_valid    (valid),
    .o_stale    (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  task automatic dwell(input logic [3:0] en, input logic [6:0] pat, input int n);
    digit_en = en;
    led      = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dwell_digit(input int d, input logic [6:0] pat, input int n);
    logic [3:0] one = 4'b0001;
    dwell(~(one << d), pat, n);
  endtask

  task automatic scan_frame(input logic [15:0] v);
    for (int d = 3; d >= 0; d--) dwell_digit(d, SEG[v[d*4 +: 4]], Dwell);
    dwell(4'hF, 7'h7F, 10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (num_bcd !== 16'h0) begin
      bad_cnt++; $display("FAIL reset_num: got %h want 0000", num_bcd);
    end
    total_cnt++;
    if (bad !== 4'h0) begin
      bad_cnt++; $display("FAIL reset_bad: got %b want 0000", bad);
    end
    total_cnt++;
    if (valid !== 1'b0) begin
      bad_cnt++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    total_cnt++;
    if (stale !== 1'b1) begin
      bad_cnt++; $display("FAIL reset_stale: got %b want 1", stale);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_short_dwell;
    v0 = valid_cnt;
    for (int k = 0; k < 8; k++) dwell_digit(3 - (k % 4), SEG[k], 500);
    dwell(4'hF, 7'h7F, 10);
    total_cnt++;
    if (valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL short_valid: got %0d pulses want 0", valid_cnt - v0);
    end
    total_cnt++;
    if (stale !== 1'b1) begin
      bad_cnt++; $display("FAIL short_stale: got %b want 1", stale);
    end
  endtask

  task automatic test_clean_frame;
    v0 = valid_cnt;
    scan_frame(16'h1234);
    total_cnt++;
    if (valid_cnt - v0 !== 1) begin
      bad_cnt++; $display("FAIL clean_pulses: got %0d want 1", valid_cnt - v0);
    end
    total_cnt++;
    if (num_bcd !== 16'h1234) begin
      bad_cnt++; $display("FAIL clean_num: got %h want 1234", num_bcd);
    end
    total_cnt++;
    if (bad !== 4'b0000) begin
      bad_cnt++; $display("FAIL clean_bad: got %b want 0000", bad);
    end
    total_cnt++;
    if (stale !== 1'b0) begin
      bad_cnt++; $display("FAIL clean_stale: got %b want 0", stale);
    end
    total_cnt++;
    if (valid !== 1'b0) begin
      bad_cnt++; $display("FAIL clean_valid_level: got %b want 0", valid);
    end
  endtask

  task automatic test_hex_bad;
    v0 = valid_cnt;
    dwell_digit(3, SEG[10], Dwell);
    dwell_digit(2, SEG[11], Dwell);
    dwell_digit(1, 7'b1111111, Dwell);
    dwell_digit(0, SEG[15], Dwell);
    dwell(4'hF, 7'h7F, 10);
    total_cnt++;
    if (valid_cnt - v0 !== 1) begin
      bad_cnt++; $display("FAIL hex_pulses: got %0d want 1", valid_cnt - v0);
    end
    total_cnt++;
    if (num_bcd !== 16'hAB0F) begin
      bad_cnt++; $display("FAIL hex_num: got %h want ab0f", num_bcd);
    end
    total_cnt++;
    if (bad !== 4'b0010) begin
      bad_cnt++; $display("FAIL hex_bad: got %b want 0010", bad);
    end
  endtask

  task automatic test_illegal_enable;
    v0 = valid_cnt;
    dwell(4'b0011, SEG[8], 5000);
    // Digits 1 and 0 alone must not complete a frame unless 0011 was sampled.
    dwell_digit(1, SEG[7], Dwell);
    dwell_digit(0, SEG[8], Dwell);
    total_cnt++;
    if (valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL illegal_no_sample: got %0d pulses want 0", valid_cnt - v0);
    end
    dwell_digit(3, SEG[5], Dwell);
    dwell_digit(2, SEG[6], Dwell);
    dwell(4'hF, 7'h7F, 10);
    total_cnt++;
    if (valid_cnt - v0 !== 1) begin
      bad_cnt++; $display("FAIL illegal_pulses: got %0d want 1", valid_cnt - v0);
    end
    total_cnt++;
    if (num_bcd !== 16'h5678) begin
      bad_cnt++; $display("FAIL illegal_num: got %h want 5678", num_bcd);
    end
  endtask

  task automatic test_timeout;
    scan_frame(16'h1234);
    total_cnt++;
    if (num_bcd !== 16'h1234 || stale !== 1'b0) begin
      bad_cnt++; $display("FAIL to_pre: got %h/%b want 1234/0", num_bcd, stale);
    end
    v0 = valid_cnt;
    dwell_digit(3, SEG[1], Dwell);
    dwell_digit(2, SEG[2], Dwell);
    dwell(4'hF, 7'h7F, 5000);
    total_cnt++;
    if (stale !== 1'b0) begin
      bad_cnt++; $display("FAIL to_early_stale: got %b want 0", stale);
    end
    dwell(4'hF, 7'h7F, 5100);
    total_cnt++;
    if (stale !== 1'b1) begin
      bad_cnt++; $display("FAIL to_stale: got %b want 1", stale);
    end
    total_cnt++;
    if (num_bcd !== 16'h1234 || valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL to_hold: got %h/%0d want 1234/0", num_bcd, valid_cnt - v0);
    end
    // Partial mask must be gone: digits 1,0 alone cannot publish.
    dwell_digit(1, SEG[14], Dwell);
    dwell_digit(0, SEG[15], Dwell);
    total_cnt++;
    if (valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL to_discard: got %0d pulses want 0", valid_cnt - v0);
    end
    dwell_digit(3, SEG[12], Dwell);
    dwell_digit(2, SEG[13], Dwell);
    dwell(4'hF, 7'h7F, 10);
    total_cnt++;
    if (num_bcd !== 16'hCDEF || stale !== 1'b0) begin
      bad_cnt++; $display("FAIL to_recover: got %h/%b want cdef/0", num_bcd, stale);
    end
  endtask

  task automatic test_reset_mid_frame;
    dwell_digit(3, SEG[9], Dwell);
    dwell_digit(2, SEG[8], Dwell);
    dwell_digit(1, SEG[7], Dwell);
    digit_en = 4'hF;
    led      = 7'h7F;
    rst_n    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (num_bcd !== 16'h0 || bad !== 4'h0 || valid !== 1'b0 || stale !== 1'b1) begin
      bad_cnt++;
      $display("FAIL mid_reset: got %h/%b/%b/%b want 0000/0000/0/1", num_bcd, bad, valid, stale);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    v0 = valid_cnt;
    dwell_digit(0, SEG[6], Dwell);
    total_cnt++;
    if (valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL mid_one_sample: got %0d pulses want 0", valid_cnt - v0);
    end
    dwell_digit(3, SEG[9], Dwell);
    dwell_digit(2, SEG[8], Dwell);
    total_cnt++;
    if (valid_cnt !== v0) begin
      bad_cnt++; $display("FAIL mid_three_samples: got %0d pulses want 0", valid_cnt - v0);
    end
    dwell_digit(1, SEG[7], Dwell);
    dwell(4'hF, 7'h7F, 10);
    total_cnt++;
    if (valid_cnt - v0 !== 1 || num_bcd !== 16'h9876) begin
      bad_cnt++;
      $display("FAIL mid_fresh: got %0d/%h want 1/9876", valid_cnt - v0, num_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_short_dwell();
    test_clean_frame();
    test_hex_bad();
    test_illegal_enable();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
